// File: rtl/systolic_feeder_v2_if.sv
// systolic_feeder_v2_if
//   Groups the configuration handshake and the skewed lane stream of
//   systolic_feeder_v2 into one bundle.
//   Config:  cfg_valid / cfg_ready handshake, cfg_ifmap_height (H),
//            cfg_ifmap_width (W), cfg_weight_height (K), cfg_op
//            (0=CONV, 1=MUL), cfg_err (one-cycle reject pulse).
//   Stream:  sd_ov (beat valid), sd_lane_valid (per lane),
//            sd_od (lane data, lane l at [l*DATA_WIDTH +: DATA_WIDTH]).
//   Modports: slave = the feeder, master = the config/stream peer.
interface systolic_feeder_v2_if #(
   parameter int DATA_WIDTH = 8,
   parameter int LANES      = 16,
   parameter int DIM_W      = 4
);
   logic                        cfg_valid;
   logic                        cfg_ready;
   logic [DIM_W-1:0]            cfg_ifmap_height;
   logic [DIM_W-1:0]            cfg_ifmap_width;
   logic [DIM_W-1:0]            cfg_weight_height;
   logic                        cfg_op;
   logic                        cfg_err;
   logic                        sd_ov;
   logic [LANES-1:0]            sd_lane_valid;
   logic [LANES*DATA_WIDTH-1:0] sd_od;

   modport slave (
      input  cfg_valid, cfg_ifmap_height, cfg_ifmap_width, cfg_weight_height, cfg_op,
      output cfg_ready, cfg_err, sd_ov, sd_lane_valid, sd_od
   );

   modport master (
      output cfg_valid, cfg_ifmap_height, cfg_ifmap_width, cfg_weight_height, cfg_op,
      input  cfg_ready, cfg_err, sd_ov, sd_lane_valid, sd_od
   );
endinterface

// File: rtl/systolic_feeder_v2.sv
// systolic_feeder_v2
//   Feeds the row inputs of the systolic array from an ifmap tile. A layer
//   config is accepted over a valid/ready handshake, per-lane (row, col)
//   offsets are precomputed over LANES cycles, and on start a diagonally
//   skewed wavefront is streamed, one beat per non-stalled cycle.
//   MUL: lane l carries row r, column l. CONV: lane l carries element
//   (l/K, l%K) of the KxK window at output position (oh, ow).
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   ifc (slave)    config handshake + lane stream (systolic_feeder_v2_if)
//   ifmap_i        tile, [row][col][bits]
//   start_i        begin stream (honoured only when a config is armed)
//   stall_i        array backpressure, freezes generator and outputs
//   busy_o         state is CALC, STREAM or DRAIN
//   done_o         one-cycle pulse after the last beat
// Build option:
//   SD_SNAPSHOT_EN  capture ifmap_i on start so upstream may change it
//                   during the stream; otherwise lanes read ifmap_i live.
module systolic_feeder_v2 #(
   parameter int DATA_WIDTH = 8,
   parameter int HEIGHT     = 8,
   parameter int WIDTH      = 8,
   parameter int LANES      = 16,
   parameter int DIM_W      = $clog2(HEIGHT) + 1
) (
   input  logic                               clk,
   input  logic                               rst,
   systolic_feeder_v2_if.slave                ifc,
   input  logic [HEIGHT*WIDTH*DATA_WIDTH-1:0] ifmap_i,
   input  logic                               start_i,
   input  logic                               stall_i,
   output logic                               busy_o,
   output logic                               done_o
);
   localparam int CNT_W = $clog2(HEIGHT*WIDTH + LANES) + 1;
   localparam int LIW   = $clog2(LANES);
   localparam int RW    = $clog2(HEIGHT);
   localparam int CW    = $clog2(WIDTH);

   typedef enum logic [2:0] {S_IDLE, S_CALC, S_ARMED, S_STREAM, S_DRAIN} state_t;
   typedef struct packed {
      logic [DIM_W-1:0] r;
      logic [DIM_W-1:0] c;
      logic             v;
   } base_t;
   typedef logic [HEIGHT-1:0][WIDTH-1:0][DATA_WIDTH-1:0] tile_t;

   state_t state_q, state_d;
   logic   cfg_ready_q, cfg_ready_d, busy_q, busy_d, done_q, err_q;

   // Held configuration and derived stream geometry
   logic [CNT_W-1:0] cfg_h, cfg_w, cfg_k, cfg_kk;
   logic             cfg_mul;
   logic [CNT_W-1:0] oh, ow, p_total, a_total, n_total;

   // Incoming config, widened for checking
   logic [CNT_W-1:0] in_h, in_w, in_k, in_kk;
   logic             cfg_ok, cfg_hs, cfg_acc;

   logic [LIW-1:0]   calc_cnt;
   logic [CNT_W-1:0] calc_r, calc_c;
   logic [DIM_W-1:0] lane_dr [LANES];
   logic [DIM_W-1:0] lane_dc [LANES];
   logic [LANES-1:0] lane_en;

   logic [CNT_W-1:0] bcnt;
   logic [DIM_W-1:0] gen_r, gen_c;
   logic             start_acc, advance, finish, emit, gen_live, calc_last;

   base_t sk_q [LANES];
   base_t sk_d [LANES];
   tile_t tile_src;

   logic [LANES-1:0]            lane_v_d, sd_lv_q;
   logic [LANES*DATA_WIDTH-1:0] lane_od_d, sd_od_q;
   logic                        sd_ov_q;

   // ---------------- config check ----------------
   assign in_h  = CNT_W'(ifc.cfg_ifmap_height);
   assign in_w  = CNT_W'(ifc.cfg_ifmap_width);
   assign in_k  = CNT_W'(ifc.cfg_weight_height);
   assign in_kk = in_k * in_k;

   assign cfg_ok = !(in_h == '0 || in_w == '0 ||
                     in_h > CNT_W'(HEIGHT) || in_w > CNT_W'(WIDTH) ||
                     (ifc.cfg_op && in_w > CNT_W'(LANES)) ||
                     (!ifc.cfg_op && (in_k == '0 || in_k > in_h || in_k > in_w ||
                                      in_kk > CNT_W'(LANES))));

   assign cfg_hs  = ifc.cfg_valid & cfg_ready_q;
   assign cfg_acc = cfg_hs & cfg_ok;

   // ---------------- stream geometry ----------------
   assign cfg_kk  = cfg_k * cfg_k;
   assign oh      = cfg_h - cfg_k + 1'b1;
   assign ow      = cfg_w - cfg_k + 1'b1;
   assign p_total = cfg_mul ? cfg_h : oh * ow;
   assign a_total = cfg_mul ? cfg_w : cfg_kk;
   assign n_total = p_total + a_total - 1'b1;

   // A config handshake in ARMED takes priority over a simultaneous start.
   assign start_acc = (state_q == S_ARMED) & start_i & ~cfg_hs;
   assign advance   = (state_q == S_STREAM || state_q == S_DRAIN) & ~stall_i;
   assign finish    = advance & (bcnt == n_total);
   assign emit      = start_acc | (advance & (bcnt != n_total));
   assign gen_live  = bcnt < p_total;
   assign calc_last = (state_q == S_CALC) && (calc_cnt == LIW'(LANES - 1));

   // ---------------- FSM ----------------
   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples pre-edge values regardless of block evaluation order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         cfg_ready_q <= 1'b1;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         cfg_ready_q <= cfg_ready_d;
         busy_q      <= busy_d;
         done_q      <= finish;
         err_q       <= cfg_hs & ~cfg_ok;
      end
   end

   // NOTE: every always_comb output gets a default first, so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (cfg_acc) state_d = S_CALC;
         S_CALC:  if (calc_last) state_d = S_ARMED;
         S_ARMED: begin
            if (cfg_acc)        state_d = S_CALC;
            else if (start_acc) state_d = S_STREAM;
         end
         S_STREAM, S_DRAIN: begin
            // The beat being emitted is index bcnt; it is a generator step
            // while bcnt < P, otherwise the skew line is only draining.
            if (finish)    state_d = S_ARMED;
            else if (emit) state_d = gen_live ? S_STREAM : S_DRAIN;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Registered outputs are decoded from the next state so they line up
   // with the state register.
   always_comb begin
      cfg_ready_d = (state_d == S_IDLE) || (state_d == S_ARMED);
      busy_d      = (state_d == S_CALC) || (state_d == S_STREAM) || (state_d == S_DRAIN);
   end

   // ---------------- config, offset and generator counters ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         cfg_h    <= '0;
         cfg_w    <= '0;
         cfg_k    <= '0;
         cfg_mul  <= 1'b0;
         calc_cnt <= '0;
         calc_r   <= '0;
         calc_c   <= '0;
         bcnt     <= '0;
         gen_r    <= '0;
         gen_c    <= '0;
      end else begin
         if (cfg_acc) begin
            cfg_h    <= in_h;
            cfg_w    <= in_w;
            cfg_k    <= in_k;
            cfg_mul  <= ifc.cfg_op;
            calc_cnt <= '0;
            calc_r   <= '0;
            calc_c   <= '0;
         end else if (state_q == S_CALC) begin
            // Walk (l/K, l%K) incrementally instead of dividing.
            calc_cnt <= calc_cnt + 1'b1;
            if (calc_c == cfg_k - 1'b1) begin
               calc_c <= '0;
               calc_r <= calc_r + 1'b1;
            end else begin
               calc_c <= calc_c + 1'b1;
            end
         end

         if (finish || cfg_acc) begin
            bcnt  <= '0;
            gen_r <= '0;
            gen_c <= '0;
         end else if (emit) begin
            bcnt <= bcnt + 1'b1;
            if (gen_live) begin
               if (cfg_mul) begin
                  gen_r <= gen_r + 1'b1;
               end else if (CNT_W'(gen_c) == ow - 1'b1) begin
                  gen_c <= '0;
                  gen_r <= gen_r + 1'b1;
               end else begin
                  gen_c <= gen_c + 1'b1;
               end
            end
         end
      end
   end

   // NOTE: the lane offset tables carry no reset; CALC rewrites every entry
   // before any stream can read them.
   always_ff @(posedge clk) begin
      if (state_q == S_CALC) begin
         lane_dr[calc_cnt] <= cfg_mul ? '0 : DIM_W'(calc_r);
         lane_dc[calc_cnt] <= cfg_mul ? DIM_W'(calc_cnt) : DIM_W'(calc_c);
         lane_en[calc_cnt] <= cfg_mul ? (CNT_W'(calc_cnt) < cfg_w) : (CNT_W'(calc_cnt) < cfg_kk);
      end
   end

   // ---------------- skew line ----------------
   // sk[l] holds the generator base delayed by l beats; the last beat
   // clears it so lanes beyond the active set cannot leak into a restart.
   always_comb begin
      for (int l = 0; l < LANES; l++) sk_d[l] = sk_q[l];
      if (emit) begin
         sk_d[0].r = gen_r;
         sk_d[0].c = gen_c;
         sk_d[0].v = gen_live;
         for (int l = 1; l < LANES; l++) sk_d[l] = sk_q[l-1];
      end else if (finish) begin
         for (int l = 0; l < LANES; l++) sk_d[l].v = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      for (int l = 0; l < LANES; l++) sk_q[l] <= rst ? '0 : sk_d[l];
   end

`ifdef SD_SNAPSHOT_EN
   tile_t snap_q;
   always_ff @(posedge clk) begin
      if (start_acc) snap_q <= ifmap_i;
   end
   // Beat 0 is formed on the capture edge itself, so it reads the live bus.
   assign tile_src = start_acc ? tile_t'(ifmap_i) : snap_q;
`else
   assign tile_src = ifmap_i;
`endif

   // Lane data formed from the post-edge skew line, then registered.
   always_comb begin
      lane_v_d  = '0;
      lane_od_d = '0;
      for (int l = 0; l < LANES; l++) begin
         if (lane_en[l] && sk_d[l].v) begin
            lane_v_d[l] = 1'b1;
            lane_od_d[l*DATA_WIDTH +: DATA_WIDTH] =
               tile_src[RW'(sk_d[l].r + lane_dr[l])][CW'(sk_d[l].c + lane_dc[l])];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sd_ov_q <= 1'b0;
         sd_lv_q <= '0;
         sd_od_q <= '0;
      end else if (emit || finish) begin
         sd_ov_q <= emit;
         sd_lv_q <= lane_v_d;
         sd_od_q <= lane_od_d;
      end
   end

   assign ifc.cfg_ready     = cfg_ready_q;
   assign ifc.cfg_err       = err_q;
   assign ifc.sd_ov         = sd_ov_q;
   assign ifc.sd_lane_valid = sd_lv_q;
   assign ifc.sd_od         = sd_od_q;
   assign busy_o            = busy_q;
   assign done_o            = done_q;
endmodule

// File: tb/tb_systolic_feeder_v2.sv
// tb_systolic_feeder_v2
//   Scoreboard bench for systolic_feeder_v2. Each start pushes the full
//   expected beat sequence, derived from the layer geometry with plain
//   division/modulo, onto a queue; a negedge monitor pops and compares
//   every fresh beat and checks that stalled beats stay frozen.
module tb_systolic_feeder_v2;
   localparam int DATA_WIDTH = 8;
   localparam int HEIGHT     = 8;
   localparam int WIDTH      = 8;
   localparam int LANES      = 16;
   localparam int DIM_W      = 4;
   localparam int VW         = LANES * DATA_WIDTH;

   typedef struct packed {
      logic [LANES-1:0] lv;
      logic [VW-1:0]    od;
   } beat_t;

   logic                               clk = 1'b0;
   logic                               rst;
   logic [HEIGHT*WIDTH*DATA_WIDTH-1:0] ifmap;
   logic                               start;
   logic                               stall;
   logic                               busy;
   logic                               done;

   int    total = 0;
   int    bad   = 0;
   beat_t exp_q [$];
   beat_t last_seen = '0;
   beat_t popped;
   logic  stall_edge = 1'b0;
   int    cur_h = 0, cur_w = 0, cur_k = 0, cur_op = 0;

   systolic_feeder_v2_if #(.DATA_WIDTH(DATA_WIDTH), .LANES(LANES), .DIM_W(DIM_W)) bus ();

   systolic_feeder_v2 #(
      .DATA_WIDTH(DATA_WIDTH), .HEIGHT(HEIGHT), .WIDTH(WIDTH), .LANES(LANES), .DIM_W(DIM_W)
   ) dut (
      .clk(clk),
      .rst(rst),
      .ifc(bus),
      .ifmap_i(ifmap),
      .start_i(start),
      .stall_i(stall),
      .busy_o(busy),
      .done_o(done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [VW-1:0] act, input logic [VW-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // ---------------- scoreboard model ----------------
   function automatic int push_expected();
      int p, a, ow, n, s, r, c, dr, dc;
      bit en;
      beat_t e;
      if (cur_op == 1) begin
         p = cur_h; a = cur_w; ow = 1;
      end else begin
         ow = cur_w - cur_k + 1;
         p  = (cur_h - cur_k + 1) * ow;
         a  = cur_k * cur_k;
      end
      n = p + a - 1;
      for (int b = 0; b < n; b++) begin
         e = '0;
         for (int l = 0; l < LANES; l++) begin
            s  = b - l;
            en = (l < a);
            if (en && s >= 0 && s < p) begin
               if (cur_op == 1) begin
                  r = s; c = 0; dr = 0; dc = l;
               end else begin
                  r = s / ow; c = s % ow; dr = l / cur_k; dc = l % cur_k;
               end
               e.lv[l] = 1'b1;
               e.od[l*DATA_WIDTH +: DATA_WIDTH] = DATA_WIDTH'(r + dr + c + dc + 1);
            end
         end
         exp_q.push_back(e);
      end
      return n;
   endfunction

   always @(posedge clk) stall_edge <= stall;

   always @(negedge clk) begin
      if (bus.sd_ov) begin
         if (stall_edge) begin
            check("stall_hold_lv", VW'(bus.sd_lane_valid), VW'(last_seen.lv));
            check("stall_hold_od", bus.sd_od, last_seen.od);
         end else if (exp_q.size() == 0) begin
            check("extra_beat", VW'(1), VW'(0));
         end else begin
            popped = exp_q.pop_front();
            check("beat_lane_valid", VW'(bus.sd_lane_valid), VW'(popped.lv));
            check("beat_data", bus.sd_od, popped.od);
            last_seen.lv = bus.sd_lane_valid;
            last_seen.od = bus.sd_od;
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic load_tile(input int h, input int w);
      for (int i = 0; i < HEIGHT; i++)
         for (int j = 0; j < WIDTH; j++)
            ifmap[(i*WIDTH + j)*DATA_WIDTH +: DATA_WIDTH] =
               (i < h && j < w) ? DATA_WIDTH'(i + j + 1) : '0;
   endtask

   task automatic do_config(input int h, input int w, input int k, input int op, input bit expect_err);
      int c;
      @(posedge clk); #1;
      bus.cfg_valid         = 1'b1;
      bus.cfg_ifmap_height  = DIM_W'(h);
      bus.cfg_ifmap_width   = DIM_W'(w);
      bus.cfg_weight_height = DIM_W'(k);
      bus.cfg_op            = op[0];
      @(posedge clk); #1;
      bus.cfg_valid = 1'b0;
      check("cfg_err", VW'(bus.cfg_err), VW'(expect_err));
      if (expect_err) begin
         check("err_ready_kept", VW'(bus.cfg_ready), VW'(1));
         check("err_not_busy", VW'(busy), VW'(0));
         @(posedge clk); #1;
         check("err_pulse_len", VW'(bus.cfg_err), VW'(0));
      end else begin
         cur_h = h; cur_w = w; cur_k = k; cur_op = op;
         check("calc_busy", VW'(busy), VW'(1));
         c = 0;
         while (!bus.cfg_ready && c < 100) begin
            @(posedge clk); #1;
            c++;
         end
         check("calc_cycles", VW'(c), VW'(LANES));
      end
   endtask

   task automatic run_stream(input int stall_at, input int stall_len);
      int n, cyc;
      bit seen;
      n = push_expected();
      @(posedge clk); #1; start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      cyc  = 0;
      seen = 1'b0;
      check("stream_busy", VW'(busy), VW'(1));
      while (!seen && cyc < 300) begin
         if (cyc == stall_at) stall = 1'b1;
         if (cyc == stall_at + stall_len) stall = 1'b0;
         @(posedge clk); #1;
         cyc++;
         if (done) seen = 1'b1;
      end
      stall = 1'b0;
      check("done_seen", VW'(seen), VW'(1));
      check("done_cycle", VW'(cyc), VW'(n + stall_len));
      check("sb_empty", VW'(exp_q.size()), VW'(0));
      check("ov_at_done", VW'(bus.sd_ov), VW'(0));
      check("idle_busy", VW'(busy), VW'(0));
      check("rearmed_ready", VW'(bus.cfg_ready), VW'(1));
      @(posedge clk); #1;
      check("done_pulse_len", VW'(done), VW'(0));
      exp_q.delete();
   endtask

   task automatic quiet_window(input string tag, input int cycles);
      logic any;
      any = 1'b0;
      for (int i = 0; i < cycles; i++) begin
         @(posedge clk); #1;
         any = any | bus.sd_ov | done | busy;
      end
      check(tag, VW'(any), VW'(0));
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int cyc;
      int n;
      rst = 1'b1; start = 1'b0; stall = 1'b0; ifmap = '0;
      bus.cfg_valid = 1'b0; bus.cfg_ifmap_height = '0; bus.cfg_ifmap_width = '0;
      bus.cfg_weight_height = '0; bus.cfg_op = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      check("rst_ready", VW'(bus.cfg_ready), VW'(1));
      check("rst_busy", VW'(busy), VW'(0));
      check("rst_done", VW'(done), VW'(0));
      check("rst_ov", VW'(bus.sd_ov), VW'(0));
      check("rst_err", VW'(bus.cfg_err), VW'(0));
      check("rst_lanes", VW'(bus.sd_lane_valid), VW'(0));
      check("rst_data", bus.sd_od, VW'(0));

      // 1: start with no config is ignored
      load_tile(8, 8);
      @(posedge clk); #1; start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      quiet_window("no_cfg_quiet", 20);

      // bad configs from IDLE
      do_config(9, 8, 0, 1, 1'b1);
      do_config(4, 0, 0, 1, 1'b1);

      // 2: MUL 8x8
      do_config(8, 8, 0, 1, 1'b0);
      run_stream(-1, 0);

      // 3: CONV 6x6 K=3
      load_tile(6, 6);
      do_config(6, 6, 3, 0, 1'b0);
      run_stream(-1, 0);

      // 4: MUL 3x8 plain, then with a 3-cycle stall at beat 4
      load_tile(3, 8);
      do_config(3, 8, 0, 1, 1'b0);
      run_stream(-1, 0);
      run_stream(4, 3);

      // 5: K*K > LANES rejected, previous MUL config still armed
      do_config(6, 6, 5, 0, 1'b1);
      run_stream(-1, 0);
      load_tile(4, 4);
      do_config(4, 4, 1, 0, 1'b0);
      run_stream(-1, 0);

      // 6: reset mid-stream at beat 5 of MUL 8x8
      load_tile(8, 8);
      do_config(8, 8, 0, 1, 1'b0);
      n = push_expected();
      @(posedge clk); #1; start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      cyc = 0;
      while (cyc < 5) begin
         @(posedge clk); #1;
         cyc++;
      end
      check("pre_rst_ov", VW'(bus.sd_ov), VW'(1));
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("abort_ov", VW'(bus.sd_ov), VW'(0));
      check("abort_lanes", VW'(bus.sd_lane_valid), VW'(0));
      check("abort_data", bus.sd_od, VW'(0));
      check("abort_done", VW'(done), VW'(0));
      check("abort_busy", VW'(busy), VW'(0));
      check("abort_ready", VW'(bus.cfg_ready), VW'(1));
      check("abort_popped", VW'(exp_q.size()), VW'(n - 6));
      exp_q.delete();
      quiet_window("abort_no_done", 10);
      @(posedge clk); #1; start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      quiet_window("abort_start_ignored", 20);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached before summary");
      $fatal(1, "timeout");
   end
endmodule
